// File: rtl/fp32_div_seq.sv
// ============================================================================
// fp32_div_seq : sequential IEEE-754 single-precision divider, round-to-zero.
//   Restoring mantissa division, one quotient bit per cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fp32_div_seq #(
   parameter int ITERS = 25
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] quotient,
   output logic        div_by_zero,
   output logic        invalid,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      NORM   = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam logic [4:0] LAST_ITER = 5'(ITERS - 1);

   state_t      state;
   logic        sign;
   logic [7:0]  ea;
   logic [7:0]  eb;
   logic [23:0] mb;
   logic [25:0] r;
   logic [24:0] q;
   logic [4:0]  cnt;

   // Operand classification on the live input buses (only used in IDLE)
   logic        a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, in_sign;
   logic        spec_hit, spec_dbz, spec_inv;
   logic [31:0] spec_q;

   always_comb begin
      a_zero   = (dividend[30:23] == 8'h00);
      a_inf    = (dividend[30:23] == 8'hFF) && (dividend[22:0] == 23'h0);
      a_nan    = (dividend[30:23] == 8'hFF) && (dividend[22:0] != 23'h0);
      b_zero   = (divisor[30:23] == 8'h00);
      b_inf    = (divisor[30:23] == 8'hFF) && (divisor[22:0] == 23'h0);
      b_nan    = (divisor[30:23] == 8'hFF) && (divisor[22:0] != 23'h0);
      in_sign  = dividend[31] ^ divisor[31];
      spec_hit = 1'b1;
      spec_dbz = 1'b0;
      spec_inv = 1'b0;
      spec_q   = 32'h0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_q   = 32'h7FC0_0000;
         spec_inv = 1'b1;
      end else if (a_inf) begin
         spec_q = {in_sign, 8'hFF, 23'h0};
      end else if (b_inf) begin
         spec_q = {in_sign, 31'h0};
      end else if (b_zero) begin
         spec_q   = {in_sign, 8'hFF, 23'h0};
         spec_dbz = 1'b1;
      end else if (a_zero) begin
         spec_q = {in_sign, 31'h0};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // Restoring step and normalize/pack datapath
   logic [25:0]        r_sub;
   logic               r_ge;
   logic signed [9:0]  norm_e;
   logic [22:0]        norm_m;
   logic [31:0]        norm_q;

   always_comb begin
      r_sub  = r - {2'b00, mb};
      r_ge   = (r >= {2'b00, mb});
      norm_e = $signed({2'b00, ea}) - $signed({2'b00, eb})
               + (q[24] ? 10'sd127 : 10'sd126);
      norm_m = q[24] ? q[23:1] : q[22:0];
      if (norm_e >= 10'sd255)
         norm_q = {sign, 8'hFF, 23'h0};
      else if (norm_e <= 10'sd0)
         norm_q = {sign, 31'h0};
      else
         norm_q = {sign, norm_e[7:0], norm_m};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         in_ready    <= 1'b1;
         out_valid   <= 1'b0;
         busy        <= 1'b0;
         quotient    <= 32'h0;
         div_by_zero <= 1'b0;
         invalid     <= 1'b0;
         sign        <= 1'b0;
         ea          <= 8'h0;
         eb          <= 8'h0;
         mb          <= 24'h0;
         r           <= 26'h0;
         q           <= 25'h0;
         cnt         <= 5'h0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  sign        <= in_sign;
                  ea          <= dividend[30:23];
                  eb          <= divisor[30:23];
                  mb          <= {1'b1, divisor[22:0]};
                  r           <= {3'b001, dividend[22:0]};
                  q           <= 25'h0;
                  cnt         <= 5'h0;
                  div_by_zero <= 1'b0;
                  invalid     <= 1'b0;
                  in_ready    <= 1'b0;
                  busy        <= 1'b1;
                  if (spec_hit) begin
                     quotient    <= spec_q;
                     div_by_zero <= spec_dbz;
                     invalid     <= spec_inv;
                     out_valid   <= 1'b1;
                     state       <= DONE;
                  end else begin
                     state <= DIVIDE;
                  end
               end
            end
            DIVIDE: begin
               if (r_ge) begin
                  q <= {q[23:0], 1'b1};
                  r <= {r_sub[24:0], 1'b0};
               end else begin
                  q <= {q[23:0], 1'b0};
                  r <= {r[24:0], 1'b0};
               end
               cnt <= cnt + 5'd1;
               if (cnt == LAST_ITER)
                  state <= NORM;
            end
            NORM: begin
               quotient  <= norm_q;
               out_valid <= 1'b1;
               state     <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fp32_div_seq.sv
// ============================================================================
// tb_fp32_div_seq : table, corner-sequence and random checks of fp32_div_seq.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fp32_div_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] dividend = 32'h0;
   logic [31:0] divisor = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] quotient;
   logic        div_by_zero;
   logic        invalid;
   logic        busy;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   fp32_div_seq #(.ITERS(25)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
      .out_ready(out_ready), .quotient(quotient), .div_by_zero(div_by_zero),
      .invalid(invalid), .busy(busy)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: exact quotient from integer arithmetic, truncated.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] res, output logic dz, output logic inv);
      int     ea, eb, e;
      longint ma, mb, mant;
      logic   s, az, ai, an, bz, bi, bn;
      ea = int'(a[30:23]); eb = int'(b[30:23]);
      s  = a[31] ^ b[31];
      az = (ea == 0); ai = (ea == 255) && (a[22:0] == 0); an = (ea == 255) && (a[22:0] != 0);
      bz = (eb == 0); bi = (eb == 255) && (b[22:0] == 0); bn = (eb == 255) && (b[22:0] != 0);
      dz = 1'b0; inv = 1'b0;
      if (an || bn || (az && bz) || (ai && bi)) begin res = 32'h7FC00000; inv = 1'b1; end
      else if (ai) res = {s, 31'h7F800000};
      else if (bi) res = {s, 31'h0};
      else if (bz) begin res = {s, 31'h7F800000}; dz = 1'b1; end
      else if (az) res = {s, 31'h0};
      else begin
         ma = longint'({1'b1, a[22:0]});
         mb = longint'({1'b1, b[22:0]});
         if (ma >= mb) begin
            mant = (ma << 23) / mb;
            e = ea - eb + 127;
         end else begin
            mant = (ma << 24) / mb;
            e = ea - eb + 126;
         end
         if (e >= 255)     res = {s, 31'h7F800000};
         else if (e <= 0)  res = {s, 31'h0};
         else              res = {s, 8'(e), 23'(mant & 64'h7FFFFF)};
      end
   endfunction

   // Issue one operation from IDLE; lat counts edges after the accept edge
   // until out_valid is seen (0 means visible right after the accept edge).
   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input bit release_out,
                        output logic [31:0] got_q, output logic got_dz, output logic got_inv,
                        output int lat);
      chk("in_ready_before_accept", 32'(in_ready), 32'd1);
      dividend = a; divisor = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = $urandom; divisor = $urandom;
      lat = 0;
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      got_q = quotient; got_dz = div_by_zero; got_inv = invalid;
      if (release_out) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
      end
   endtask

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic        dz;
      logic        inv;
      int          lat;
   } vec_t;

   localparam int NV = 16;
   vec_t vecs[NV];

   initial begin
      logic [31:0] gq, mq, ra, rb, hold_q;
      logic        gdz, ginv, mdz, minv;
      int          lat;

      vecs[0]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 26};
      vecs[1]  = '{32'h40C00000, 32'h40400000, 32'h40000000, 1'b0, 1'b0, 26};
      vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0, 1'b0, 26};
      vecs[3]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 1'b1, 1'b0, 0};
      vecs[4]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 1'b0, 1'b1, 0};
      vecs[5]  = '{32'hBF800000, 32'h7F800000, 32'h80000000, 1'b0, 1'b0, 0};
      vecs[6]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 1'b0, 1'b0, 26};
      vecs[7]  = '{32'h00800000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, 26};
      vecs[8]  = '{32'hC0C00000, 32'h40400000, 32'hC0000000, 1'b0, 1'b0, 26};
      vecs[9]  = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 1'b0, 1'b1, 0};
      vecs[10] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b1, 0};
      vecs[11] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 1'b0, 1'b0, 0};
      vecs[12] = '{32'h00400000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 0};
      vecs[13] = '{32'hC0000000, 32'h80000000, 32'h7F800000, 1'b1, 1'b0, 0};
      vecs[14] = '{32'h3FC00000, 32'h3F800000, 32'h3FC00000, 1'b0, 1'b0, 26};
      vecs[15] = '{32'h40000000, 32'h3FC00000, 32'h3FAAAAAA, 1'b0, 1'b0, 26};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_quotient", quotient, 32'h0);
      chk("rst_flags", {30'h0, div_by_zero, invalid}, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].a, vecs[i].b, 1'b1, gq, gdz, ginv, lat);
         chk($sformatf("vec%0d_quotient", i), gq, vecs[i].q);
         chk($sformatf("vec%0d_dbz", i), 32'(gdz), 32'(vecs[i].dz));
         chk($sformatf("vec%0d_invalid", i), 32'(ginv), 32'(vecs[i].inv));
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      end

      // Back-pressure: result held 10 cycles, new operands ignored
      do_op(32'h40C00000, 32'h40400000, 1'b0, gq, gdz, ginv, lat);
      hold_q = gq;
      chk("bp_first_quotient", gq, 32'h40000000);
      dividend = 32'h3F800000; divisor = 32'h00000000; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         chk("bp_quotient_stable", quotient, hold_q);
         chk("bp_out_valid", 32'(out_valid), 32'd1);
         chk("bp_in_ready", 32'(in_ready), 32'd0);
         chk("bp_flags", {30'h0, div_by_zero, invalid}, 32'h0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("bp_release_in_ready", 32'(in_ready), 32'd1);
      chk("bp_release_out_valid", 32'(out_valid), 32'd0);
      do_op(32'h3F800000, 32'h40400000, 1'b1, gq, gdz, ginv, lat);
      chk("bp_next_quotient", gq, 32'h3EAAAAAA);
      chk("bp_next_latency", 32'(lat), 32'd26);

      // Reset at DIVIDE iteration 12
      dividend = 32'h3F800000; divisor = 32'h40400000; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      chk("mid_busy_before_rst", 32'(busy), 32'd1);
      rst = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      out_ready = 1'b0;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_quotient", quotient, 32'h0);
      do_op(32'h40C00000, 32'h40400000, 1'b1, gq, gdz, ginv, lat);
      chk("post_rst_quotient", gq, 32'h40000000);
      chk("post_rst_latency", 32'(lat), 32'd26);

      // Random operands against the reference model
      for (int i = 0; i < 200; i++) begin
         ra = $urandom; rb = $urandom;
         case ($urandom_range(0, 9))
            0: ra[30:23] = 8'h00;
            1: rb[30:23] = 8'h00;
            2: begin ra[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) ra[22:0] = 23'h0; end
            3: begin rb[30:23] = 8'hFF; if ($urandom_range(0, 1) == 0) rb[22:0] = 23'h0; end
            default: begin
               if (ra[30:23] == 8'hFF || ra[30:23] == 8'h00) ra[30:23] = 8'h7F;
               if (rb[30:23] == 8'hFF || rb[30:23] == 8'h00) rb[30:23] = 8'h80;
            end
         endcase
         model(ra, rb, mq, mdz, minv);
         do_op(ra, rb, 1'b1, gq, gdz, ginv, lat);
         chk($sformatf("rand%0d_quotient a=%h b=%h", i, ra, rb), gq, mq);
         chk($sformatf("rand%0d_flags a=%h b=%h", i, ra, rb),
             {30'h0, gdz, ginv}, {30'h0, mdz, minv});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
